// File: rtl/wb_sram_bist_pkg.sv
// Shared types, defaults and helpers for the Wishbone SRAM march BIST.
package wb_sram_bist_pkg;

  localparam int unsigned DEF_DEPTH_W = 9;
  localparam int unsigned DEF_TIMEOUT = 255;
  localparam int unsigned TMO_W       = 8;
  localparam int unsigned WB_W        = 32;
  localparam int unsigned SEL_W       = 4;
  localparam int unsigned ERR_W       = 16;

  typedef enum logic [2:0] {
    IDLE, M0_W, M1_R, M1_W, M2_R, GAP, DONE
  } state_e;

  typedef enum logic [1:0] {
    EL_M0, EL_M1, EL_M2, EL_NONE
  } elem_e;

  function automatic logic is_access(input state_e s);
    return (s == M0_W) || (s == M1_R) || (s == M1_W) || (s == M2_R);
  endfunction

  function automatic elem_e elem_of(input state_e s);
    case (s)
      M0_W:       return EL_M0;
      M1_R, M1_W: return EL_M1;
      M2_R:       return EL_M2;
      default:    return EL_NONE;
    endcase
  endfunction

  // True background for M0 writes and M1 reads; inverted for M1 writes and M2 reads.
  function automatic logic [WB_W-1:0] bg_word(input state_e s, input logic [WB_W-1:0] pat);
    return ((s == M0_W) || (s == M1_R)) ? pat : ~pat;
  endfunction

endpackage

// File: rtl/wb_bist_timeout.sv
// Loadable down-counter flagging a Wishbone request that has waited TIMEOUT cycles.
module wb_bist_timeout
  import wb_sram_bist_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic run_i,
  output logic expired_c
);

  localparam logic [TMO_W-1:0] LOAD_VAL = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (!run_i) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TMO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Expires in the TIMEOUT-th cycle of an outstanding request.
  assign expired_c = run_i && (cnt_q == '0);

endmodule

// File: rtl/wb_sram_bist.sv
// Wishbone master running a 3-element march (up W P; up R P/W ~P; down R ~P) over an SRAM region.
module wb_sram_bist
  import wb_sram_bist_pkg::*;
#(
  parameter int unsigned DEPTH_W = DEF_DEPTH_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start_i,
  input  logic [WB_W-1:0]    base_i,
  input  logic [DEPTH_W-1:0] last_i,
  input  logic [WB_W-1:0]    pattern_i,
  output logic               m_cyc_o,
  output logic               m_stb_o,
  output logic               m_we_o,
  output logic [SEL_W-1:0]   m_sel_o,
  output logic [WB_W-1:0]    m_adr_o,
  output logic [WB_W-1:0]    m_dat_o,
  input  logic               m_ack_i,
  input  logic [WB_W-1:0]    m_dat_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic               timeout_o,
  output logic [WB_W-1:0]    fail_adr_o,
  output logic [ERR_W-1:0]   err_cnt_o
);

  state_e               state_q, state_d;
  state_e               op_q, op_d;
  logic [DEPTH_W-1:0]   idx_q, idx_d;
  logic [DEPTH_W-1:0]   last_q, last_d;
  logic [WB_W-1:0]      base_q, base_d;
  logic [WB_W-1:0]      pat_q, pat_d;

  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [WB_W-1:0]      adr_q, adr_d;
  logic [WB_W-1:0]      dat_q, dat_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 tmo_q, tmo_d;
  logic [WB_W-1:0]      fail_adr_q, fail_adr_d;
  logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;

  logic                 start_acc_c;
  logic                 tmo_exp_c;
  logic                 tmo_hit_c;
  logic                 mismatch_c;

  assign start_acc_c = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign tmo_hit_c   = is_access(state_q) && !m_ack_i && tmo_exp_c;
  assign mismatch_c  = m_ack_i && ((state_q == M1_R) || (state_q == M2_R)) &&
                       (m_dat_i != bg_word(state_q, pat_q));

  wb_bist_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .load_i    (is_access(state_d) && !is_access(state_q)),
    .run_i     (is_access(state_q)),
    .expired_c (tmo_exp_c)
  );

  // State and run-configuration registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      op_q    <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      base_q  <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      base_q  <= base_d;
      pat_q   <= pat_d;
    end
  end

  // Next state; GAP picks the next access from the one just completed.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    last_d  = last_q;
    base_d  = base_q;
    pat_d   = pat_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = M0_W;
          idx_d   = '0;
          last_d  = last_i;
          base_d  = base_i;
          pat_d   = pattern_i;
        end
      end
      M0_W, M1_R, M1_W, M2_R: begin
        if (m_ack_i) begin
          state_d = GAP;
          op_d    = state_q;
        end else if (tmo_exp_c) begin
          state_d = DONE;
        end
      end
      GAP: begin
        case (elem_of(op_q))
          EL_M0: begin
            if (idx_q == last_q) begin
              state_d = M1_R;
              idx_d   = '0;
            end else begin
              state_d = M0_W;
              idx_d   = idx_q + DEPTH_W'(1);
            end
          end
          EL_M1: begin
            if (op_q == M1_R) begin
              state_d = M1_W;
            end else if (idx_q == last_q) begin
              state_d = M2_R;
              idx_d   = last_q;
            end else begin
              state_d = M1_R;
              idx_d   = idx_q + DEPTH_W'(1);
            end
          end
          EL_M2: begin
            if (idx_q == '0) begin
              state_d = DONE;
            end else begin
              state_d = M2_R;
              idx_d   = idx_q - DEPTH_W'(1);
            end
          end
          default: state_d = DONE;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs follow the next state, so they line up with state_q.
  always_comb begin
    req_d      = is_access(state_d);
    we_d       = (state_d == M0_W) || (state_d == M1_W);
    sel_d      = req_d ? {SEL_W{1'b1}} : '0;
    adr_d      = req_d ? (base_d + (WB_W'(idx_d) << 2)) : '0;
    dat_d      = we_d ? bg_word(state_d, pat_d) : '0;
    err_cnt_d  = err_cnt_q;
    fail_adr_d = fail_adr_q;
    tmo_d      = tmo_q;
    if (start_acc_c) begin
      err_cnt_d  = '0;
      fail_adr_d = '0;
      tmo_d      = 1'b0;
    end else if (mismatch_c) begin
      if (err_cnt_q == '0) fail_adr_d = adr_q;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
    end else if (tmo_hit_c) begin
      tmo_d = 1'b1;
    end
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_cnt_d == '0) && !tmo_d;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      tmo_q      <= 1'b0;
      fail_adr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      req_q      <= req_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      tmo_q      <= tmo_d;
      fail_adr_q <= fail_adr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign m_cyc_o    = req_q;
  assign m_stb_o    = req_q;
  assign m_we_o     = we_q;
  assign m_sel_o    = sel_q;
  assign m_adr_o    = adr_q;
  assign m_dat_o    = dat_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign timeout_o  = tmo_q;
  assign fail_adr_o = fail_adr_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_wb_sram_bist.sv
// Bench for wb_sram_bist: table of march runs against a Wishbone SRAM slave model with a transaction scoreboard.
module tb_wb_sram_bist;

  localparam int unsigned DW  = 9;
  localparam int unsigned TMO = 10;

  typedef struct {
    logic          we;
    logic [31:0]   adr;
    logic [31:0]   dat;
  } tx_t;

  typedef struct {
    logic [31:0]   base;
    logic [DW-1:0] last;
    logic [31:0]   pat;
    bit            stuck_en;
    logic [31:0]   stuck_adr;
    int            hang_n;
    int            mid_start;
    bit            exp_pass;
    logic [15:0]   exp_err;
    logic [31:0]   exp_fail;
    bit            exp_tmo;
    int            exp_ntx;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          start_i;
  logic [31:0]   base_i;
  logic [DW-1:0] last_i;
  logic [31:0]   pattern_i;
  logic          m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]    m_sel_o;
  logic [31:0]   m_adr_o, m_dat_o;
  logic          m_ack_i;
  logic [31:0]   m_dat_i;
  logic          busy_o, done_o, pass_o, timeout_o;
  logic [31:0]   fail_adr_o;
  logic [15:0]   err_cnt_o;

  int            n_vec, n_err;
  int            n_tx, hang_n, hang_len, req_len, gap_len;
  bit            seen, cur_hang, force_ack, stuck_en;
  logic [31:0]   stuck_adr;
  logic          h_we;
  logic [31:0]   h_adr, h_dat;
  tx_t           sb[$];
  logic [31:0]   mem [logic [31:0]];
  vec_t          tbl [7];

  wb_sram_bist #(
    .DEPTH_W (DW),
    .TIMEOUT (TMO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start_i    (start_i),
    .base_i     (base_i),
    .last_i     (last_i),
    .pattern_i  (pattern_i),
    .m_cyc_o    (m_cyc_o),
    .m_stb_o    (m_stb_o),
    .m_we_o     (m_we_o),
    .m_sel_o    (m_sel_o),
    .m_adr_o    (m_adr_o),
    .m_dat_o    (m_dat_o),
    .m_ack_i    (m_ack_i),
    .m_dat_i    (m_dat_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pass_o     (pass_o),
    .timeout_o  (timeout_o),
    .fail_adr_o (fail_adr_o),
    .err_cnt_o  (err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
                 busy_o, done_o, pass_o, timeout_o, fail_adr_o, err_cnt_o});
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] d;
    d = mem.exists(a) ? mem[a] : 32'h0;
    if (stuck_en && (a == stuck_adr)) d[0] = 1'b0;
    return d;
  endfunction

  // Slave model: one wait state per request; each request is scored when it first appears.
  always @(negedge clk) begin
    if (rst) begin
      m_ack_i = 1'b0;
      m_dat_i = 32'h0;
      seen    = 1'b0;
    end else if (force_ack) begin
      m_ack_i = 1'b1;
      m_dat_i = $urandom;
    end else if (m_ack_i) begin
      m_ack_i = 1'b0;
      seen    = 1'b0;
      gap_len = m_cyc_o ? 0 : 1;
    end else if (m_cyc_o && m_stb_o) begin
      if (!seen) begin
        tx_t e;
        seen     = 1'b1;
        req_len  = 0;
        n_tx++;
        if (n_tx > 1) check("gap_len", 128'(gap_len), 128'(1));
        if (sb.size() == 0) begin
          check("extra_tx", 128'(n_tx), 128'(0));
        end else begin
          e = sb.pop_front();
          check("tx", 128'({m_we_o, m_sel_o, m_adr_o, m_we_o ? m_dat_o : 32'h0}),
                      128'({e.we, 4'hF, e.adr, e.we ? e.dat : 32'h0}));
        end
        h_we     = m_we_o;
        h_adr    = m_adr_o;
        h_dat    = m_dat_o;
        cur_hang = (n_tx == hang_n);
      end else begin
        check("req_stable", 128'({m_we_o, m_adr_o, m_dat_o}), 128'({h_we, h_adr, h_dat}));
      end
      req_len++;
      m_ack_i = !cur_hang && (req_len >= 2);
      if (m_ack_i) begin
        if (m_we_o) mem[m_adr_o] = m_dat_o;
        else        m_dat_i = rd_word(m_adr_o);
      end
    end else begin
      if (seen) begin
        hang_len = req_len;
        seen     = 1'b0;
      end
      gap_len++;
    end
  end

  task automatic load_sb(input vec_t v);
    sb.delete();
    mem.delete();
    for (int i = 0; i <= int'(v.last); i++)
      sb.push_back('{1'b1, v.base + 32'(4 * i), v.pat});
    for (int i = 0; i <= int'(v.last); i++) begin
      sb.push_back('{1'b0, v.base + 32'(4 * i), v.pat});
      sb.push_back('{1'b1, v.base + 32'(4 * i), ~v.pat});
    end
    for (int i = int'(v.last); i >= 0; i--)
      sb.push_back('{1'b0, v.base + 32'(4 * i), ~v.pat});
  endtask

  task automatic run_vec(input vec_t v);
    int  cyc;
    int  total;
    bit  mid_fired;
    total = 4 * (int'(v.last) + 1);
    @(negedge clk);
    load_sb(v);
    n_tx      = 0;
    hang_len  = 0;
    hang_n    = v.hang_n;
    stuck_en  = v.stuck_en;
    stuck_adr = v.stuck_adr;
    base_i    = v.base;
    last_i    = v.last;
    pattern_i = v.pat;
    start_i   = 1'b1;
    @(negedge clk);
    start_i   = 1'b0;
    base_i    = $urandom;
    last_i    = DW'($urandom);
    pattern_i = $urandom;
    check("start_clear", 128'({m_cyc_o, m_stb_o, busy_o, done_o, pass_o, timeout_o, fail_adr_o, err_cnt_o}),
                         128'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0}));
    cyc = 0;
    mid_fired = 1'b0;
    while (!done_o && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (start_i) begin
        start_i = 1'b0;
      end else if (v.mid_start != 0 && !mid_fired && n_tx == v.mid_start) begin
        start_i   = 1'b1;
        mid_fired = 1'b1;
      end
    end
    start_i = 1'b0;
    check("done_seen", 128'(done_o), 128'(1));
    repeat (3) @(negedge clk);
    check("result", 128'({busy_o, done_o, pass_o, timeout_o, fail_adr_o, err_cnt_o}),
                    128'({1'b0, 1'b1, v.exp_pass, v.exp_tmo, v.exp_fail, v.exp_err}));
    check("done_idle_bus", 128'({m_cyc_o, m_stb_o}), 128'(0));
    check("tx_count", 128'(n_tx), 128'(v.exp_ntx));
    check("sb_left", 128'(sb.size()), 128'(total - v.exp_ntx));
    if (v.hang_n != 0) check("timeout_len", 128'(hang_len), 128'(TMO));
  endtask

  task automatic reset_mid(input vec_t v);
    @(negedge clk);
    load_sb(v);
    n_tx      = 0;
    hang_n    = 1;
    stuck_en  = 1'b0;
    base_i    = v.base;
    last_i    = v.last;
    pattern_i = v.pat;
    start_i   = 1'b1;
    @(negedge clk);
    start_i   = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_req", 128'({m_cyc_o, m_stb_o, busy_o}), 128'(3'b111));
    #2 rst = 1'b1;
    #1 check("rst_async", all_outs(), 128'(0));
    @(negedge clk);
    rst       = 1'b0;
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("late_ack", all_outs(), 128'(0));
    force_ack = 1'b0;
    hang_n    = 0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0;
    n_tx = 0; hang_n = 0; hang_len = 0; req_len = 0; gap_len = 0;
    seen = 1'b0; cur_hang = 1'b0; force_ack = 1'b0; stuck_en = 1'b0; stuck_adr = 32'h0;
    h_we = 1'b0; h_adr = 32'h0; h_dat = 32'h0;
    m_ack_i = 1'b0; m_dat_i = 32'h0;
    start_i = 1'b0; base_i = 32'h0; last_i = '0; pattern_i = 32'h0;
    rst = 1'b1;

    tbl[0] = '{base:32'h3000_0000, last:9'd3, pat:32'hA5A5_A5A5, stuck_en:1'b0, stuck_adr:32'h0,
               hang_n:0, mid_start:0, exp_pass:1'b1, exp_err:16'd0, exp_fail:32'h0, exp_tmo:1'b0, exp_ntx:16};
    tbl[1] = '{base:32'h3000_0000, last:9'd3, pat:32'hFFFF_FFFF, stuck_en:1'b1, stuck_adr:32'h3000_0008,
               hang_n:0, mid_start:0, exp_pass:1'b0, exp_err:16'd1, exp_fail:32'h3000_0008, exp_tmo:1'b0, exp_ntx:16};
    tbl[2] = '{base:32'h3000_0000, last:9'd3, pat:32'h1234_5678, stuck_en:1'b0, stuck_adr:32'h0,
               hang_n:3, mid_start:0, exp_pass:1'b0, exp_err:16'd0, exp_fail:32'h0, exp_tmo:1'b1, exp_ntx:3};
    tbl[3] = '{base:32'hFFFF_FFF8, last:9'd3, pat:32'h0F0F_0F0F, stuck_en:1'b0, stuck_adr:32'h0,
               hang_n:0, mid_start:0, exp_pass:1'b1, exp_err:16'd0, exp_fail:32'h0, exp_tmo:1'b0, exp_ntx:16};
    tbl[4] = '{base:32'h0000_1000, last:9'd0, pat:32'h5A5A_5A5A, stuck_en:1'b0, stuck_adr:32'h0,
               hang_n:0, mid_start:0, exp_pass:1'b1, exp_err:16'd0, exp_fail:32'h0, exp_tmo:1'b0, exp_ntx:4};
    tbl[5] = '{base:32'h3000_0000, last:9'd3, pat:32'hC3C3_C3C3, stuck_en:1'b0, stuck_adr:32'h0,
               hang_n:0, mid_start:6, exp_pass:1'b1, exp_err:16'd0, exp_fail:32'h0, exp_tmo:1'b0, exp_ntx:16};
    tbl[6] = '{base:32'h2000_0000, last:9'd7, pat:32'h0000_0000, stuck_en:1'b1, stuck_adr:32'h2000_0004,
               hang_n:0, mid_start:0, exp_pass:1'b0, exp_err:16'd1, exp_fail:32'h2000_0004, exp_tmo:1'b0, exp_ntx:32};

    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", all_outs(), 128'(0));

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    reset_mid(tbl[0]);
    run_vec(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
